queue: RTL and testbench
========================

// Module: queue
// PURPOSE
//  Synchronous byte FIFO queue controlled by a 2-bit opcode per cycle.
//  Stores up to DEPTH entries; supports enqueue, dequeue and combined enqueue+dequeue.
//  Reports registered head-of-line output and empty/full status flags.
//  Used as a general buffering element between producer/consumer logic on one clock.
// PARAMETERS
//  WIDTH  8  data width of in/out in bits
//  DEPTH  8  number of storage entries; power of two, >= 2
// PORTS
//  clk        input   1      system clock, all state updates on rising edge
//  rst        input   1      reset: one clock; asynchronous, active-low (0 = reset)
//  operation  input   2      opcode: 0 NOP, 1 ENQ, 2 DEQ, 3 ENQ+DEQ
//  in         input   WIDTH  data to enqueue (used for ENQ / ENQ+DEQ only)
//  out        output  WIDTH  registered data from the most recent successful dequeue
//  empty      output  1      1 when queue holds 0 entries (registered)
//  full       output  1      1 when queue holds DEPTH entries (registered)
// BEHAVIOUR
//  - Reset (rst=0, async): out=0, empty=1, full=0, head/tail ptr=0, count=0; storage contents don't-care.
//  - All updates on posedge clk; outputs reflect an op one cycle after it is presented (valid before next posedge).
//  - NOP(0): no state change; out holds.
//  - ENQ(1): if !full, mem[tail]<=in, tail++, count++; if full, op ignored (no overwrite, no error flag).
//  - DEQ(2): if !empty, out<=mem[head], head++, count--; if empty, op ignored, out holds previous value.
//  - ENQ+DEQ(3):
//     * non-empty, non-full: out<=mem[head], write in at tail, both ptrs++, count unchanged.
//     * empty: behaves as ENQ only; out holds.
//     * full: dequeue and enqueue both occur (write lands in slot freed by the read); count stays DEPTH, full stays 1.
//  - Pointers wrap modulo DEPTH (DEPTH-1 -> 0).
//  - FIFO order strictly preserved across wrap-around.
//  - empty = (count==0), full = (count==DEPTH); both derived from registered count/next-state, never glitch.
//  - count width $clog2(DEPTH)+1 bits; never exceeds DEPTH nor underflows.
//  - Reset asserted mid-operation discards all contents immediately; the first op after release sees an empty queue.
//  - in is don't-care for NOP/DEQ; X on in during those ops must not propagate.
// CONFIGURATION
//  QUEUE_COUNT_EN defined:
//    adds output port count [$clog2(DEPTH):0] = current occupancy (registered, 0 after reset).
//  QUEUE_COUNT_EN undefined:
//    no count port; occupancy tracked internally only; all other behaviour identical.
// TESTING
//  1. Reset then NOP x3 -> out=0, empty=1, full=0 every cycle.
//  2. ENQ 10,20,30 then DEQ x3 -> out=10,20,30 in successive cycles; empty=1 after third DEQ.
//  3. ENQ 1..8 (DEPTH=8) -> full=1 after 8th; ENQ 99 ignored; DEQ x8 -> out=1..8, no 99; empty=1.
//  4. DEQ on empty after out=8 -> out stays 8, empty=1, full=0.
//  5. ENQ+DEQ on empty with in=5 -> empty=0, out unchanged; ENQ+DEQ in=6 -> out=5, count stays 1.
//  6. Fill to full, ENQ+DEQ in=77 -> out=old head, full=1; drain x8 -> 77 emerges last (wrap check);
//     assert rst mid-stream -> empty=1, out=0 asynchronously.

Source files
------------

// File: rtl/queue.sv
// queue: opcode-driven synchronous FIFO with registered head-of-line output and empty/full flags.
// Define QUEUE_COUNT_EN to expose the registered occupancy on output port count.
module queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full
`ifdef QUEUE_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             do_enq, do_deq;
  // A dequeue frees a slot, so a combined op on a full queue may still enqueue.
  always_comb begin
    do_deq  = operation[1] & ~empty_q;
    do_enq  = operation[0] & (~full_q | do_deq);
    head_d  = do_deq ? head_q + AW'(1) : head_q;
    tail_d  = do_enq ? tail_q + AW'(1) : tail_q;
    cnt_d   = (do_enq & ~do_deq) ? cnt_q + (AW+1)'(1) :
              (do_deq & ~do_enq) ? cnt_q - (AW+1)'(1) : cnt_q;
    out_d   = do_deq ? mem[head_q] : out_q;
    empty_d = cnt_d == '0;
    full_d  = cnt_d == (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_enq) mem[tail_q] <= in;
  end
  assign out   = out_q;
  assign empty = empty_q;
  assign full  = full_q;
`ifdef QUEUE_COUNT_EN
  assign count = cnt_q;
`endif
endmodule

// File: tb/tb_queue.sv
// tb_queue: directed self-checking bench for queue (WIDTH=8, DEPTH=8).
module tb_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] operation = 2'd0;
  logic [7:0] in = 8'd0;
  logic [7:0] out;
  logic       empty, full;
  int         vecs = 0;
  int         errs = 0;
`ifdef QUEUE_COUNT_EN
  logic [3:0] count;
`endif
  queue #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .operation(operation), .in(in),
    .out(out), .empty(empty), .full(full)
`ifdef QUEUE_COUNT_EN
    , .count(count)
`endif
  );
  always #5 clk = ~clk;
  task automatic step(input logic [1:0] o, input logic [7:0] d);
    operation = o;
    in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 8'hA5);
      vecs++;
      if (out !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
        errs++;
        $display("FAIL reset_nop%0d: out=%0d empty=%b full=%b, want out=0 empty=1 full=0", i, out, empty, full);
      end
    end
  endtask
  task automatic test_fifo_order;
    logic [7:0] exp [3];
    exp = '{8'd10, 8'd20, 8'd30};
    for (int i = 0; i < 3; i++) step(2'd1, exp[i]);
    vecs++;
    if (empty !== 1'b0 || out !== 8'd0) begin
      errs++;
      $display("FAIL enq3: empty=%b out=%0d, want empty=0 out=0", empty, out);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'd2, 8'hxx);
      vecs++;
      if (out !== exp[i]) begin
        errs++;
        $display("FAIL deq%0d: out=%0d, want %0d", i, out, exp[i]);
      end
    end
    vecs++;
    if (empty !== 1'b1) begin
      errs++;
      $display("FAIL deq_empty: empty=%b, want 1", empty);
    end
  endtask
  task automatic test_full;
    for (int i = 1; i <= 8; i++) begin
      step(2'd1, 8'(i));
      vecs++;
      if (full !== (i == 8)) begin
        errs++;
        $display("FAIL fill%0d: full=%b, want %b", i, full, i == 8);
      end
    end
    step(2'd1, 8'd99);
    vecs++;
    if (full !== 1'b1 || out !== 8'd30) begin
      errs++;
      $display("FAIL enq_on_full: full=%b out=%0d, want full=1 out=30", full, out);
    end
    for (int i = 1; i <= 8; i++) begin
      step(2'd2, 8'hxx);
      vecs++;
      if (out !== 8'(i) || full !== 1'b0) begin
        errs++;
        $display("FAIL drain%0d: out=%0d full=%b, want out=%0d full=0", i, out, full, i);
      end
    end
    vecs++;
    if (empty !== 1'b1) begin
      errs++;
      $display("FAIL drain_empty: empty=%b, want 1", empty);
    end
  endtask
  task automatic test_deq_empty;
    step(2'd2, 8'hxx);
    vecs++;
    if (out !== 8'd8 || empty !== 1'b1 || full !== 1'b0) begin
      errs++;
      $display("FAIL deq_on_empty: out=%0d empty=%b full=%b, want out=8 empty=1 full=0", out, empty, full);
    end
  endtask
  task automatic test_enq_deq;
    step(2'd3, 8'd5);
    vecs++;
    if (empty !== 1'b0 || out !== 8'd8) begin
      errs++;
      $display("FAIL ed_empty: empty=%b out=%0d, want empty=0 out=8", empty, out);
    end
    step(2'd3, 8'd6);
    vecs++;
    if (out !== 8'd5 || empty !== 1'b0 || full !== 1'b0) begin
      errs++;
      $display("FAIL ed_mid: out=%0d empty=%b full=%b, want out=5 empty=0 full=0", out, empty, full);
    end
`ifdef QUEUE_COUNT_EN
    vecs++;
    if (count !== 4'd1) begin
      errs++;
      $display("FAIL ed_count: count=%0d, want 1", count);
    end
`endif
    step(2'd2, 8'hxx);
    vecs++;
    if (out !== 8'd6 || empty !== 1'b1) begin
      errs++;
      $display("FAIL ed_drain: out=%0d empty=%b, want out=6 empty=1", out, empty);
    end
  endtask
  task automatic test_wrap_reset;
    for (int i = 0; i < 8; i++) step(2'd1, 8'(11 + i));
    step(2'd3, 8'd77);
    vecs++;
    if (out !== 8'd11 || full !== 1'b1) begin
      errs++;
      $display("FAIL ed_full: out=%0d full=%b, want out=11 full=1", out, full);
    end
`ifdef QUEUE_COUNT_EN
    vecs++;
    if (count !== 4'd8) begin
      errs++;
      $display("FAIL ed_full_count: count=%0d, want 8", count);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      step(2'd2, 8'hxx);
      vecs++;
      if (out !== ((i == 7) ? 8'd77 : 8'(12 + i))) begin
        errs++;
        $display("FAIL wrap%0d: out=%0d, want %0d", i, out, (i == 7) ? 77 : 12 + i);
      end
    end
    vecs++;
    if (empty !== 1'b1) begin
      errs++;
      $display("FAIL wrap_empty: empty=%b, want 1", empty);
    end
    step(2'd1, 8'd40);
    step(2'd1, 8'd41);
    step(2'd1, 8'd42);
    step(2'd2, 8'hxx);
    #2;
    rst = 1'b0;
    #1;
    vecs++;
    if (out !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errs++;
      $display("FAIL async_rst: out=%0d empty=%b full=%b, want out=0 empty=1 full=0", out, empty, full);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(2'd2, 8'hxx);
    vecs++;
    if (out !== 8'd0 || empty !== 1'b1) begin
      errs++;
      $display("FAIL post_rst_deq: out=%0d empty=%b, want out=0 empty=1", out, empty);
    end
    step(2'd1, 8'd55);
    step(2'd2, 8'hxx);
    vecs++;
    if (out !== 8'd55 || empty !== 1'b1) begin
      errs++;
      $display("FAIL post_rst_fifo: out=%0d empty=%b, want out=55 empty=1", out, empty);
    end
  endtask
  initial begin
    test_reset;
    test_fifo_order;
    test_full;
    test_deq_empty;
    test_enq_deq;
    test_wrap_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
